// File: rtl/cpu_mem_bridge.sv
// rtl/cpu_mem_bridge.sv - CPU / block-RAM / memory-mapped I/O bridge with program loader
module cpu_mem_bridge #(
  parameter logic [9:0] IO_BASE  = 10'h3F0,
  parameter logic [9:0] LOAD_MAX = 10'h3EF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic [9:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        ram_we,
  output logic [9:0]  ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  input  logic [9:0]  sw_in,
  output logic [9:0]  led_out,
  output logic [15:0] hex_out,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [15:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        cpu_hold
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t      state, state_nxt;
  logic [9:0]  ld_ptr;
  logic        done_sticky;
  logic        overflow;
  logic [9:0]  sw_meta, sw_sync;
  logic        rd_sel_ram;
  logic [15:0] io_rdata_q;
  logic [15:0] io_mux;

  logic       is_ram;
  logic [9:0] io_off;
  logic       ld_xfer;
  logic       ld_end;

  assign is_ram  = (cpu_addr < IO_BASE);
  assign io_off  = cpu_addr - IO_BASE;
  assign ld_xfer = (state == LOAD) && ld_valid;
  assign ld_end  = ld_xfer && (ld_last || (ld_ptr == LOAD_MAX));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and RAM-port / handshake outputs; reset forces ram_we low combinationally
  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ld_ready  = 1'b0;
    cpu_hold  = 1'b0;
    case (state)
      IDLE: begin
        ram_we = cpu_we && is_ram;
        if (ld_start) state_nxt = LOAD;
      end
      LOAD: begin
        cpu_hold  = 1'b1;
        ld_ready  = 1'b1;
        ram_addr  = ld_ptr;
        ram_wdata = ld_data;
        ram_we    = ld_valid;
        if (ld_end) state_nxt = DONE;
      end
      DONE: begin
        cpu_hold  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) ram_we = 1'b0;
  end

  // Load pointer and sticky load status; the pointer stops advancing once LOAD exits at LOAD_MAX
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_ptr      <= '0;
      done_sticky <= 1'b0;
      overflow    <= 1'b0;
    end else if (state == IDLE && ld_start) begin
      ld_ptr      <= '0;
      done_sticky <= 1'b0;
      overflow    <= 1'b0;
    end else if (ld_xfer) begin
      ld_ptr <= ld_ptr + 10'd1;
      if (ld_ptr == LOAD_MAX && !ld_last) overflow <= 1'b1;
    end else if (state == DONE) begin
      done_sticky <= 1'b1;
    end
  end

  // LED / HEX registers; CPU writes only land while the CPU owns the bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out <= '0;
      hex_out <= '0;
    end else if (state == IDLE && cpu_we && !is_ram) begin
      if (io_off == 10'd0) led_out <= cpu_wdata[9:0];
      if (io_off == 10'd1) hex_out <= cpu_wdata;
    end
  end

  // Two-flop synchronizer for the asynchronous switches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  // I/O read mux over pre-edge register values, so a same-cycle write reads back the old value
  always_comb begin
    io_mux = '0;
    case (io_off)
      10'd0:   io_mux = {6'd0, led_out};
      10'd1:   io_mux = hex_out;
      10'd2:   io_mux = {6'd0, sw_sync};
      10'd3:   io_mux = {13'd0, overflow, done_sticky, state == LOAD};
      default: io_mux = '0;
    endcase
  end

  // Read-select and I/O read data registered to match the RAM's one-cycle latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_sel_ram <= 1'b1;
      io_rdata_q <= '0;
    end else begin
      rd_sel_ram <= is_ram;
      io_rdata_q <= io_mux;
    end
  end

  assign cpu_rdata = (state != IDLE) ? 16'h0000 : (rd_sel_ram ? ram_rdata : io_rdata_q);

endmodule
